// File: rtl/rv_pkg.sv
// Shared decode types for the instruction decode stage: opclass and FSM state
// enums, RV32I major opcodes, and per-class register-usage helpers.
package rv_pkg;

    typedef enum logic [3:0] {
        OC_OP      = 4'h0,
        OC_OP_IMM  = 4'h1,
        OC_LOAD    = 4'h2,
        OC_STORE   = 4'h3,
        OC_BRANCH  = 4'h4,
        OC_JAL     = 4'h5,
        OC_JALR    = 4'h6,
        OC_LUI     = 4'h7,
        OC_AUIPC   = 4'h8,
        OC_SYSTEM  = 4'h9,
        OC_ILLEGAL = 4'hF
    } opclass_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic opclass_e decode_opclass(input logic [6:0] opcode);
        opclass_e oc;
        case (opcode)
            OPC_OP:     oc = OC_OP;
            OPC_OP_IMM: oc = OC_OP_IMM;
            OPC_LOAD:   oc = OC_LOAD;
            OPC_STORE:  oc = OC_STORE;
            OPC_BRANCH: oc = OC_BRANCH;
            OPC_JAL:    oc = OC_JAL;
            OPC_JALR:   oc = OC_JALR;
            OPC_LUI:    oc = OC_LUI;
            OPC_AUIPC:  oc = OC_AUIPC;
            OPC_SYSTEM: oc = OC_SYSTEM;
            default:    oc = OC_ILLEGAL;
        endcase
        return oc;
    endfunction

    function automatic logic uses_rs1(input opclass_e oc);
        return (oc == OC_OP) || (oc == OC_OP_IMM) || (oc == OC_LOAD) ||
               (oc == OC_STORE) || (oc == OC_BRANCH) || (oc == OC_JALR);
    endfunction

    function automatic logic uses_rs2(input opclass_e oc);
        return (oc == OC_OP) || (oc == OC_STORE) || (oc == OC_BRANCH);
    endfunction

    function automatic logic writes_rd(input opclass_e oc);
        return (oc == OC_OP) || (oc == OC_OP_IMM) || (oc == OC_LOAD) ||
               (oc == OC_JAL) || (oc == OC_JALR) || (oc == OC_LUI) ||
               (oc == OC_AUIPC);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate format from the
// already-decoded opclass and sign-extends it to 32 bits.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    input  opclass_e    opclass,
    output logic [31:0] imm
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // SYSTEM carries no operand immediate here, so it shares the zero path with OP.
    always_comb begin
        imm = 32'h0;
        case (opclass)
            OC_OP_IMM, OC_LOAD, OC_JALR: imm = imm_i;
            OC_STORE:                    imm = imm_s;
            OC_BRANCH:                   imm = imm_b;
            OC_JAL:                      imm = imm_j;
            OC_LUI, OC_AUIPC:            imm = imm_u;
            default:                     imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: latches a fetched word, reads the register file, stalls on
// scoreboard hazards, and presents registered operands to execute.
module instr_decode
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic        instr_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] imm,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [3:0]  opclass,
    output logic        illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q, pend_d;

    logic [31:0] op_a_q, op_b_q, imm_q, pc_out_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic        f7b5_q;
    opclass_e    oc_q;
    logic        ill_q;

    opclass_e    cls;
    logic [31:0] imm_c;
    logic        hazard;
    logic        accept;
    logic        capture;
    logic        retire;

    assign cls = decode_opclass(instr_q[6:0]);
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    imm_gen u_imm_gen (
        .instr   (instr_q),
        .opclass (cls),
        .imm     (imm_c)
    );

    // pend_q[0] is held at zero, so x0 can never raise a hazard.
    assign hazard = (uses_rs1(cls) && pend_q[rs1]) ||
                    (uses_rs2(cls) && pend_q[rs2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (instr_valid) state_d = ST_READ;
                ST_READ:  if (!hazard)     state_d = ST_VALID;
                ST_VALID: if (dec_ready)   state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_ready = 1'b0;
        dec_valid   = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid && !flush;
            end
            ST_READ: begin
                capture = !hazard && !flush;
            end
            ST_VALID: begin
                dec_valid = 1'b1;
                retire    = dec_ready && !flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
        end else if (accept) begin
            instr_q <= instr;
            pc_q    <= instr_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= 32'h0;
            op_b_q   <= 32'h0;
            imm_q    <= 32'h0;
            pc_out_q <= 32'h0;
            rd_q     <= 5'd0;
            f3_q     <= 3'd0;
            f7b5_q   <= 1'b0;
            oc_q     <= OC_ILLEGAL;
            ill_q    <= 1'b0;
        end else if (capture) begin
            op_a_q   <= rs1_data;
            op_b_q   <= rs2_data;
            imm_q    <= imm_c;
            pc_out_q <= pc_q;
            rd_q     <= (cls == OC_ILLEGAL) ? 5'd0 : instr_q[11:7];
            f3_q     <= instr_q[14:12];
            f7b5_q   <= instr_q[30];
            oc_q     <= cls;
            ill_q    <= (cls == OC_ILLEGAL);
        end
    end

    // Writeback clears first so a same-edge retire to the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (retire && writes_rd(oc_q) && (rd_q != 5'd0)) begin
            pend_d[rd_q] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 32'h0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign imm      = imm_q;
    assign pc_out   = pc_out_q;
    assign rd_out   = rd_q;
    assign funct3   = f3_q;
    assign funct7b5 = f7b5_q;
    assign opclass  = oc_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: a decode vector table plus hand-written
// stall, flush, hold and asynchronous-reset sequences against a small regfile model.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] op_a, op_b, imm, pc_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [3:0]  opclass;
    logic        illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    logic [31:0] rf [32];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1];
    assign rs2_data = rf[rs2];

    instr_decode dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .imm         (imm),
        .pc_out      (pc_out),
        .rd_out      (rd_out),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .opclass     (opclass),
        .illegal     (illegal),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [3:0]  oc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [31:0] i, pc, a, b, im, input logic [3:0] oc,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic f7, il);
        vec_t v;
        v.instr = i; v.pc = pc; v.op_a = a; v.op_b = b; v.imm = im;
        v.oc = oc; v.rd = rd; v.f3 = f3; v.f7b5 = f7; v.ill = il;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] pc);
        @(negedge clk);
        instr       = i;
        instr_pc    = pc;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic retire();
        @(negedge clk);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("idle_after_retire", instr_ready, 1'b1);
        check("dv_after_retire", dec_valid, 1'b0);
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] val);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = r;
        step();
        wb_valid = 1'b0;
        rf[r]    = val;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.instr, v.pc);
        check("dv_in_read", dec_valid, 1'b0);
        check("rdy_in_read", instr_ready, 1'b0);
        step();
        check("dv_latency", dec_valid, 1'b1);
        check("opclass", opclass, v.oc);
        check("imm", imm, v.imm);
        check("rd_out", rd_out, v.rd);
        check("illegal", illegal, v.ill);
        check("op_a", op_a, v.op_a);
        check("op_b", op_b, v.op_b);
        check("pc_out", pc_out, v.pc);
        check("funct3", funct3, v.f3);
        check("funct7b5", funct7b5, v.f7b5);
        retire();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'h0;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
        dec_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

        //            instr          pc         op_a          op_b          imm           oc    rd  f3 f7 il
        vecs[0]  = mk(32'h00700293, 32'h100, 32'h0,      32'h1007, 32'h7,        4'h1, 5,  0, 0, 0);
        vecs[1]  = mk(32'h12345537, 32'h104, 32'h1008,   32'h1003, 32'h12345000, 4'h7, 10, 5, 0, 0);
        vecs[2]  = mk(32'hFE20AC23, 32'h108, 32'h1001,   32'h1002, 32'hFFFFFFF8, 4'h3, 24, 2, 1, 0);
        vecs[3]  = mk(32'h001005EF, 32'h10C, 32'h0,      32'h1001, 32'h800,      4'h5, 11, 0, 0, 0);
        vecs[4]  = mk(32'hFFDFF66F, 32'h110, 32'h101F,   32'h101D, 32'hFFFFFFFC, 4'h5, 12, 7, 1, 0);
        vecs[5]  = mk(32'hFFF22683, 32'h114, 32'h1004,   32'h101F, 32'hFFFFFFFF, 4'h2, 13, 2, 1, 0);
        vecs[6]  = mk(32'h80000717, 32'h118, 32'h0,      32'h0,    32'h80000000, 4'h8, 14, 0, 0, 0);
        vecs[7]  = mk(32'h010187E7, 32'h11C, 32'h1003,   32'h1010, 32'h10,       4'h6, 15, 0, 0, 0);
        vecs[8]  = mk(32'h40208833, 32'h120, 32'h1001,   32'h1002, 32'h0,        4'h0, 16, 0, 1, 0);
        vecs[9]  = mk(32'h00000073, 32'h124, 32'h0,      32'h0,    32'h0,        4'h9, 0,  0, 0, 0);
        vecs[10] = mk(32'h0000057F, 32'h128, 32'h0,      32'h0,    32'h0,        4'hF, 0,  0, 0, 1);
        vecs[11] = mk(32'h0000000F, 32'h12C, 32'h0,      32'h0,    32'h0,        4'hF, 0,  0, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_instr_ready", instr_ready, 1'b1);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_opclass", opclass, 4'hF);
        check("rst_illegal", illegal, 1'b0);
        check("rst_op_a", op_a, 32'h0);
        check("rst_imm", imm, 32'h0);
        check("rst_rd_out", rd_out, 5'd0);
        check("rst_rs1", rs1, 5'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // ADD x6,x5,x5 stalls on pending x5 until writeback.
        issue(32'h00528333, 32'h200);
        check("stall_rs1", rs1, 5'd5);
        check("stall_rs2", rs2, 5'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_dv", dec_valid, 1'b0);
            check("stall_rdy", instr_ready, 1'b0);
        end
        writeback(5'd5, 32'h7);
        check("stall_dv_wb_edge", dec_valid, 1'b0);
        step();
        check("wb_dv", dec_valid, 1'b1);
        check("wb_op_a", op_a, 32'h7);
        check("wb_op_b", op_b, 32'h7);
        check("wb_rd_out", rd_out, 5'd6);
        rf[5] = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_dv", dec_valid, 1'b1);
            check("hold_rdy", instr_ready, 1'b0);
            check("hold_op_a", op_a, 32'h7);
            check("hold_rd", rd_out, 5'd6);
            check("hold_oc", opclass, 4'h0);
        end
        retire();

        // BEQ x0,x0,-4: no pending bit for its rd field (x29).
        issue(32'hFE000EE3, 32'h300);
        step();
        check("beq_dv", dec_valid, 1'b1);
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_oc", opclass, 4'h4);
        retire();
        issue(32'h000E83B3, 32'h304);
        step();
        check("x29_not_pending", dec_valid, 1'b1);
        check("x29_op_a", op_a, 32'h101D);

        // Retire of rd x7 coincides with a writeback of x7: x7 stays pending.
        @(negedge clk);
        dec_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
        step();
        dec_ready = 1'b0; wb_valid = 1'b0;
        issue(32'h00138413, 32'h308);
        step();
        check("setwins_stall1", dec_valid, 1'b0);
        step();
        check("setwins_stall2", dec_valid, 1'b0);
        writeback(5'd7, 32'h77);
        step();
        check("setwins_dv", dec_valid, 1'b1);
        check("setwins_op_a", op_a, 32'h77);
        check("setwins_imm", imm, 32'h1);
        retire();

        // Flush beats instr_valid in IDLE.
        @(negedge clk);
        instr = 32'h00000013; instr_valid = 1'b1; flush = 1'b1;
        step();
        instr_valid = 1'b0; flush = 1'b0;
        check("flush_idle_rdy", instr_ready, 1'b1);
        step();
        check("flush_idle_dv", dec_valid, 1'b0);

        // Flush in READ drops the word; pending x8 survives.
        issue(32'h000404B3, 32'h400);
        step();
        @(negedge clk);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_read_rdy", instr_ready, 1'b1);
        check("flush_read_dv", dec_valid, 1'b0);
        step();
        check("flush_read_dv2", dec_valid, 1'b0);
        issue(32'h000404B3, 32'h404);
        step();
        check("x8_still_pending1", dec_valid, 1'b0);
        step();
        check("x8_still_pending2", dec_valid, 1'b0);
        writeback(5'd8, 32'h88);
        step();
        check("x8_dv", dec_valid, 1'b1);
        check("x8_op_a", op_a, 32'h88);

        // Flush with dec_ready in VALID: no handshake, x9 not marked.
        @(negedge clk);
        flush = 1'b1; dec_ready = 1'b1;
        step();
        flush = 1'b0; dec_ready = 1'b0;
        check("flush_valid_rdy", instr_ready, 1'b1);
        check("flush_valid_dv", dec_valid, 1'b0);
        issue(32'h000488B3, 32'h408);
        step();
        check("x9_not_pending", dec_valid, 1'b1);
        check("x9_op_a", op_a, 32'h1009);

        // Asynchronous reset while VALID.
        #2;
        rst = 1'b1;
        #1;
        check("arst_dv", dec_valid, 1'b0);
        check("arst_rdy", instr_ready, 1'b1);
        check("arst_op_a", op_a, 32'h0);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_oc", opclass, 4'hF);
        check("arst_rd", rd_out, 5'd0);
        check("arst_rs1", rs1, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h00050933, 32'h500);
        step();
        check("x10_cleared_by_rst", dec_valid, 1'b1);
        check("x10_op_a", op_a, 32'h100A);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports instr_valid (in, 1), instr (in, 32), instr_pc (in, 32), instr_ready (out, 1): fetch handshake.
REQ-004 SHALL have ports rs1 and rs2 (out, 5 each): register-file read addresses.
REQ-005 SHALL have ports rs1_data and rs2_data (in, 32 each): combinational register-file read data.
REQ-006 SHALL have ports dec_valid (out, 1) and dec_ready (in, 1): execute-stage handshake.
REQ-007 SHALL have ports op_a, op_b, imm, pc_out (out, 32 each), rd_out (out, 5), funct3 (out, 3), funct7b5 (out, 1), opclass (out, 4), illegal (out, 1).
REQ-008 SHALL have ports wb_valid (in, 1) and wb_rd (in, 5): writeback completion notice, same cycle as the register-file write.
REQ-009 SHALL have port flush (in, 1): discards any held instruction.

Function
REQ-010 SHALL implement FSM IDLE, READ, VALID; instr_ready = 1 only in IDLE; dec_valid = 1 only in VALID.
REQ-011 IDLE: on instr_valid, latch instr and instr_pc, go to READ.
REQ-012 READ: drive rs1 = instr[19:15] and rs2 = instr[24:20] of the latched word; rs1/rs2 outputs hold those fields in every state.
REQ-013 READ: on no hazard, capture op_a = rs1_data, op_b = rs2_data, imm, and decoded fields into output registers, go to VALID; on hazard, stay in READ.
REQ-014 Hazard SHALL be: the registered pending bit is set for rs1 when rs1 is used, or for rs2 when rs2 is used; x0 is never pending.
REQ-015 rs1 used by OP, OP_IMM, LOAD, STORE, BRANCH, JALR; rs2 used by OP, STORE, BRANCH; rd written by OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC.
REQ-016 VALID: outputs held stable; on dec_ready, set pending[rd_out] if the class writes rd and rd_out != 0, go to IDLE.
REQ-017 Minimum latency: instruction accepted at edge N, dec_valid high after edge N+1; throughput is one instruction per 3 cycles.
REQ-018 wb_valid SHALL clear pending[wb_rd] at the same edge; a stalled READ captures on the following cycle, when the register file returns the written value.
REQ-019 Same-edge set and clear of one register: set wins.
REQ-020 imm SHALL be sign-extended I/S/B/J formats and U format (instr[31:12] << 12), per opclass; zero for OP, SYSTEM, ILLEGAL.
REQ-021 opclass encodings: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL; any other opcode[6:0] is ILLEGAL.
REQ-022 ILLEGAL: presented with illegal = 1, rd_out = 0, and no pending bit set on handshake.
REQ-023 flush: next state IDLE from any state, held instruction dropped, pending mask unchanged; flush overrides instr_valid and dec_ready in the same cycle.

Reset
REQ-024 rst SHALL force IDLE, pending = 0, and all output registers to 0 (opclass = ILLEGAL code 0xF, illegal = 0).
REQ-025 rst asserted mid-operation SHALL discard the held instruction with no handshake completing.

Structure
REQ-026 Package rv_pkg SHALL hold the opclass enum, opcode constants, and the FSM state enum.
REQ-027 Immediate generation SHALL be a combinational sub-module imm_gen(instr, opclass -> imm).

Verification
REQ-028 Reset, then ADDI x5,x0,7 (0x00700293) at pc 0x100 -> dec_valid after 2 cycles; opclass OP_IMM, imm 7, rd_out 5, op_a 0, pc_out 0x100.
REQ-029 ADD x6,x5,x5 issued while pending[5] set -> stalls in READ; wb_valid with wb_rd 5 and regfile value 7 -> next cycle op_a = op_b = 7.
REQ-030 BEQ with imm = -4 -> imm 0xFFFFFFFC, opclass BRANCH, no pending bit set after handshake.
REQ-031 dec_ready held low for 5 cycles -> all outputs stable, instr_ready 0; then dec_ready high -> IDLE next cycle.
REQ-032 opcode 0x7F -> illegal 1, rd_out 0; flush during READ -> IDLE, no dec_valid, pending unchanged.
REQ-033 rst asserted in VALID -> outputs 0 immediately (asynchronous), pending cleared.
